// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions for the RV32 hazard controller: result-source, forwarding
// and FSM state encodings plus the stall/flush control bundle.
package hazard_controller_pkg;

    localparam logic [1:0] RES_SRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] S_INIT     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_ERR      = 2'd3;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    // Full pipeline freeze used while the data memory is busy or has timed out.
    localparam hz_ctrl_t CTRL_FREEZE = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                         stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                         flush_w: 1'b1};

endpackage

// File: rtl/hazard_controller_forwarding_unit.sv
// E-stage operand forwarding selects; M-stage result has priority over W, x0 never forwards.
module forwarding_unit
    import hazard_controller_pkg::*;
(
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e
);

    function automatic logic [1:0] sel(input logic [4:0] rs, input logic [4:0] rdm,
                                       input logic wm, input logic [4:0] rdw,
                                       input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs)
            return FWD_MEM;
        else if (ww && rdw != 5'd0 && rdw == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a_e = sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    assign fwd_b_e = sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage RV32 core: stall/flush generation, load-use interlock,
// data-memory wait FSM with timeout, and saturating stall/flush performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int INIT_FLUSH = 2,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rs1_e,
    input  logic [4:0]           rs2_e,
    input  logic [4:0]           rd_e,
    input  logic [1:0]           res_src_e,
    input  logic                 pc_src_e,
    input  logic [4:0]           rd_m,
    input  logic                 reg_write_m,
    input  logic [4:0]           rd_w,
    input  logic                 reg_write_w,
    input  logic                 dmem_req_m,
    input  logic                 dmem_ready_m,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_w,
    output logic [1:0]           fwd_a_e,
    output logic [1:0]           fwd_b_e,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int IW = (INIT_FLUSH > 1) ? $clog2(INIT_FLUSH) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic [IW-1:0] init_cnt;
    logic [WW-1:0] wait_cnt;
    logic          lw_hz;
    logic          mem_busy;
    hz_ctrl_t      ctrl;

    forwarding_unit u_fwd (
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .rd_w        (rd_w),
        .reg_write_w (reg_write_w),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e)
    );

    assign lw_hz    = (res_src_e == RES_SRC_LOAD) && (rd_e != 5'd0)
                      && (rd_e == rs1_d || rd_e == rs2_d);
    assign mem_busy = dmem_req_m && !dmem_ready_m;

    always_comb begin
        ctrl = '0;
        case (state)
            S_INIT: begin
                ctrl.stall_f = 1'b1;
                ctrl.flush_d = 1'b1;
                ctrl.flush_e = 1'b1;
                ctrl.flush_w = 1'b1;
            end
            S_RUN: begin
                // A pending memory access overrides both load-use and branch handling.
                if (mem_busy) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl.stall_f = lw_hz && !pc_src_e;
                    ctrl.stall_d = lw_hz;
                    ctrl.flush_d = pc_src_e;
                    ctrl.flush_e = lw_hz || pc_src_e;
                end
            end
            default: ctrl = CTRL_FREEZE;
        endcase
    end

    assign stall_f = ctrl.stall_f;
    assign stall_d = ctrl.stall_d;
    assign stall_e = ctrl.stall_e;
    assign stall_m = ctrl.stall_m;
    assign flush_d = ctrl.flush_d;
    assign flush_e = ctrl.flush_e;
    assign flush_w = ctrl.flush_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl.stall_f && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ctrl.flush_e && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;

            case (state)
                S_INIT: begin
                    if (init_cnt == IW'(INIT_FLUSH - 1))
                        state <= S_RUN;
                    else
                        init_cnt <= init_cnt + 1'b1;
                end
                S_RUN: begin
                    if (mem_busy) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= WW'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (dmem_ready_m) begin
                        state <= S_RUN;
                    end else if (wait_cnt == WW'(TIMEOUT)) begin
                        state   <= S_ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a behavioural model predicts every cycle's outputs,
// a separate monitor pops the predictions and compares them against the DUT.
module tb_hazard_controller;

    localparam int INIT_FLUSH = 2;
    localparam int TIMEOUT    = 64;
    localparam int CW         = 4;
    localparam int CMAX       = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]    res_src_e;
    logic          pc_src_e, reg_write_m, reg_write_w, dmem_req_m, dmem_ready_m;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    hazard_controller #(.INIT_FLUSH(INIT_FLUSH), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .res_src_e(res_src_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .dmem_req_m(dmem_req_m), .dmem_ready_m(dmem_ready_m),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        bit rst;
        int rs1_d, rs2_d, rs1_e, rs2_e, rd_e, res_src, rd_m, rd_w;
        bit pc_src, rwm, rww, req, ready;
    } in_t;

    typedef struct {
        int sf, sd, se, sm, fd, fe, fw, fa, fb, me, sc, fc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Model state: cycles of forced bubbles left, memory-wait progress, sticky error, counters.
    int  init_left;
    bit  waiting, err, mvalid = 0, have_prev = 0;
    int  wait_cycles, m_sc, m_fc, m_me;
    in_t prev;

    function automatic int fwd(int rs, in_t i);
        if (i.rwm && i.rd_m != 0 && i.rd_m == rs) return 2;
        if (i.rww && i.rd_w != 0 && i.rd_w == rs) return 1;
        return 0;
    endfunction

    function automatic exp_t model_out(in_t i);
        exp_t e;
        bit lw;
        e = '{default: 0};
        lw = (i.res_src == 1) && (i.rd_e != 0) && (i.rd_e == i.rs1_d || i.rd_e == i.rs2_d);
        if (init_left > 0) begin
            e.sf = 1; e.fd = 1; e.fe = 1; e.fw = 1;
        end else if (err || waiting || (i.req && !i.ready)) begin
            e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.fw = 1;
        end else begin
            e.sf = lw && !i.pc_src;
            e.sd = lw;
            e.fd = i.pc_src;
            e.fe = lw || i.pc_src;
        end
        e.fa = fwd(i.rs1_e, i);
        e.fb = fwd(i.rs2_e, i);
        e.me = m_me;
        e.sc = m_sc;
        e.fc = m_fc;
        return e;
    endfunction

    task automatic model_update(in_t p);
        exp_t o;
        if (p.rst) begin
            init_left = INIT_FLUSH; waiting = 0; err = 0; wait_cycles = 0;
            m_sc = 0; m_fc = 0; m_me = 0; mvalid = 1;
            return;
        end
        if (!mvalid) return;
        o = model_out(p);
        if (o.sf != 0) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        if (o.fe != 0) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        if (init_left > 0) begin
            init_left--;
        end else if (err) begin
        end else if (waiting) begin
            if (p.ready) waiting = 0;
            else if (wait_cycles == TIMEOUT) begin err = 1; m_me = 1; end
            else wait_cycles++;
        end else if (p.req && !p.ready) begin
            waiting = 1; wait_cycles = 1;
        end
    endtask

    task automatic drive(in_t i);
        rst = i.rst;
        rs1_d = 5'(i.rs1_d); rs2_d = 5'(i.rs2_d); rs1_e = 5'(i.rs1_e); rs2_e = 5'(i.rs2_e);
        rd_e = 5'(i.rd_e); res_src_e = 2'(i.res_src); pc_src_e = i.pc_src;
        rd_m = 5'(i.rd_m); reg_write_m = i.rwm; rd_w = 5'(i.rd_w); reg_write_w = i.rww;
        dmem_req_m = i.req; dmem_ready_m = i.ready;
    endtask

    task automatic step(in_t i);
        @(posedge clk); #1;
        if (have_prev) model_update(prev);
        drive(i);
        prev = i; have_prev = 1;
        if (mvalid) q.push_back(model_out(i));
    endtask

    function automatic in_t zero_in();
        in_t z;
        z = '{default: 0};
        return z;
    endfunction

    function automatic in_t rnd_in();
        in_t r;
        r.rst = ($urandom_range(0, 199) == 0);
        r.rs1_d = $urandom_range(0, 3); r.rs2_d = $urandom_range(0, 3);
        r.rs1_e = $urandom_range(0, 3); r.rs2_e = $urandom_range(0, 3);
        r.rd_e = $urandom_range(0, 3); r.rd_m = $urandom_range(0, 3); r.rd_w = $urandom_range(0, 3);
        r.res_src = $urandom_range(0, 3);
        r.pc_src = ($urandom_range(0, 5) == 0);
        r.rwm = 1'($urandom); r.rww = 1'($urandom);
        r.req = ($urandom_range(0, 3) == 0);
        r.ready = 1'($urandom);
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_f", int'(stall_f), e.sf);
                chk("stall_d", int'(stall_d), e.sd);
                chk("stall_e", int'(stall_e), e.se);
                chk("stall_m", int'(stall_m), e.sm);
                chk("flush_d", int'(flush_d), e.fd);
                chk("flush_e", int'(flush_e), e.fe);
                chk("flush_w", int'(flush_w), e.fw);
                chk("fwd_a_e", int'(fwd_a_e), e.fa);
                chk("fwd_b_e", int'(fwd_b_e), e.fb);
                chk("mem_err", int'(mem_err), e.me);
                chk("stall_cnt", int'(stall_cnt), e.sc);
                chk("flush_cnt", int'(flush_cnt), e.fc);
            end
        end
    end

    initial begin
        in_t i;
        drive(zero_in());
        rst = 1'b1;

        i = zero_in(); i.rst = 1;
        repeat (3) step(i);
        i = zero_in();
        repeat (4) step(i);

        // forwarding priority and x0 suppression
        i.rs1_e = 5; i.rd_m = 5; i.rwm = 1; i.rd_w = 5; i.rww = 1; step(i);
        i.rwm = 0; step(i);
        i.rs1_e = 0; i.rd_m = 0; i.rd_w = 0; i.rwm = 1; step(i);
        i = zero_in(); i.rs2_e = 7; i.rd_w = 7; i.rww = 1; step(i);

        // load-use, alone and with a same-cycle taken branch
        i = zero_in(); i.res_src = 1; i.rd_e = 4; i.rs2_d = 4; step(i);
        i.pc_src = 1; step(i);
        i = zero_in(); i.res_src = 1; i.rd_e = 0; i.rs1_d = 0; step(i);
        i = zero_in(); step(i);

        // memory wait with a held branch, released after 3 busy cycles
        i = zero_in(); i.req = 1; i.pc_src = 1;
        repeat (3) step(i);
        i.ready = 1; step(i);
        i = zero_in(); i.pc_src = 1; step(i);
        i = zero_in(); repeat (2) step(i);

        // timeout into the error state, then reset recovery
        i = zero_in(); i.req = 1;
        repeat (TIMEOUT + 6) step(i);
        i.ready = 1; repeat (2) step(i);
        i = zero_in(); i.rst = 1; repeat (2) step(i);
        i = zero_in(); repeat (4) step(i);

        // reset in the middle of a memory wait
        i = zero_in(); i.req = 1; repeat (5) step(i);
        i.rst = 1; step(i);
        i = zero_in(); repeat (4) step(i);

        repeat (3000) step(rnd_in());

        i = zero_in(); step(i);
        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
